// File: rtl/writeback_stage.sv
// MEM/WB stage: holds one retiring instruction, waits for load data when needed,
// and issues a registered one-cycle write pulse to the register bank.
module writeback_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regWrite,
   input  logic [REG_AW-1:0] in_wAddr,
   input  logic [1:0]        in_wbSel,
   input  logic [DATA_W-1:0] in_aluResult,
   input  logic [DATA_W-1:0] in_pcPlus4,
   input  logic [1:0]        in_memSize,
   input  logic              in_memUnsigned,
   input  logic [1:0]        in_byteOff,
   input  logic              flush,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] wrData,
   output logic [REG_AW-1:0] wAddr,
   output logic              regWriteFlag,
   output logic              load_pending,
   output logic [REG_AW-1:0] load_addr,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

   state_t            state, stateNext;
   logic [REG_AW-1:0] lAddr, lAddrNext;
   logic              lRegWrite, lRegWriteNext;
   logic [1:0]        lMemSize, lMemSizeNext;
   logic [1:0]        lByteOff, lByteOffNext;
   logic              lMemUnsigned, lMemUnsignedNext;
   logic [DATA_W-1:0] wrDataNext;
   logic [REG_AW-1:0] wAddrNext;
   logic              regWriteFlagNext;
   logic              accept;

   function automatic logic [DATA_W-1:0] extractLoad(
      input logic [DATA_W-1:0] rdata,
      input logic [1:0]        size,
      input logic [1:0]        off,
      input logic              uns
   );
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b00:   extractLoad = {{(DATA_W-8){b[7] & ~uns}}, b};
         2'b01:   extractLoad = {{(DATA_W-16){h[15] & ~uns}}, h};
         default: extractLoad = rdata;
      endcase
   endfunction

   assign in_ready     = (state == IDLE || state == COMMIT) && !flush;
   assign accept       = in_valid && in_ready;
   assign load_pending = (state == WAIT);
   assign load_addr    = (state == WAIT) ? lAddr : '0;
   assign busy         = (state != IDLE);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      stateNext        = state;
      lAddrNext        = lAddr;
      lRegWriteNext    = lRegWrite;
      lMemSizeNext     = lMemSize;
      lByteOffNext     = lByteOff;
      lMemUnsignedNext = lMemUnsigned;
      wrDataNext       = wrData;
      wAddrNext        = wAddr;
      regWriteFlagNext = 1'b0;
      case (state)
         IDLE, COMMIT: begin
            if (accept) begin
               lAddrNext        = in_wAddr;
               lRegWriteNext    = in_regWrite;
               lMemSizeNext     = in_memSize;
               lByteOffNext     = in_byteOff;
               lMemUnsignedNext = in_memUnsigned;
               if (in_wbSel == 2'b01) begin
                  stateNext = WAIT;
               end else begin
                  stateNext        = COMMIT;
                  wrDataNext       = (in_wbSel == 2'b10) ? in_pcPlus4 : in_aluResult;
                  wAddrNext        = in_wAddr;
                  regWriteFlagNext = in_regWrite && (in_wAddr != '0);
               end
            end else begin
               stateNext = IDLE;
            end
         end
         WAIT: begin
            // Flush wins over data arriving in the same cycle.
            if (flush) begin
               stateNext = IDLE;
            end else if (mem_rvalid) begin
               stateNext        = COMMIT;
               wrDataNext       = extractLoad(mem_rdata, lMemSize, lByteOff, lMemUnsigned);
               wAddrNext        = lAddr;
               regWriteFlagNext = lRegWrite && (lAddr != '0);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lAddr        <= '0;
         lRegWrite    <= 1'b0;
         lMemSize     <= 2'b00;
         lByteOff     <= 2'b00;
         lMemUnsigned <= 1'b0;
         wrData       <= '0;
         wAddr        <= '0;
         regWriteFlag <= 1'b0;
      end else begin
         state        <= stateNext;
         lAddr        <= lAddrNext;
         lRegWrite    <= lRegWriteNext;
         lMemSize     <= lMemSizeNext;
         lByteOff     <= lByteOffNext;
         lMemUnsigned <= lMemUnsignedNext;
         wrData       <= wrDataNext;
         wAddr        <= wAddrNext;
         regWriteFlag <= regWriteFlagNext;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: inputs change and outputs are
// sampled on the falling edge, the DUT captures on the rising edge.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_regWrite, in_memUnsigned;
   logic [4:0]  in_wAddr;
   logic [1:0]  in_wbSel, in_memSize, in_byteOff;
   logic [31:0] in_aluResult, in_pcPlus4;
   logic        flush, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] wrData;
   logic [4:0]  wAddr, load_addr;
   logic        regWriteFlag, load_pending, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_regWrite(in_regWrite),
      .in_wAddr(in_wAddr), .in_wbSel(in_wbSel), .in_aluResult(in_aluResult),
      .in_pcPlus4(in_pcPlus4), .in_memSize(in_memSize), .in_memUnsigned(in_memUnsigned),
      .in_byteOff(in_byteOff), .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wrData(wrData), .wAddr(wAddr), .regWriteFlag(regWriteFlag),
      .load_pending(load_pending), .load_addr(load_addr), .busy(busy)
   );

   task automatic idle_inputs();
      in_valid = 1'b0; in_regWrite = 1'b0; in_wAddr = '0; in_wbSel = 2'b00;
      in_aluResult = '0; in_pcPlus4 = '0; in_memSize = 2'b10; in_memUnsigned = 1'b0;
      in_byteOff = 2'b00; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic drive_op(input logic [1:0] sel, input logic [4:0] addr, input logic rw,
                           input logic [31:0] alu, input logic [31:0] pc4);
      in_valid = 1'b1; in_wbSel = sel; in_wAddr = addr; in_regWrite = rw;
      in_aluResult = alu; in_pcPlus4 = pc4;
   endtask

   task automatic drive_load(input logic [1:0] size, input logic uns, input logic [1:0] off,
                             input logic [4:0] addr);
      in_valid = 1'b1; in_wbSel = 2'b01; in_memSize = size; in_memUnsigned = uns;
      in_byteOff = off; in_wAddr = addr; in_regWrite = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive_op(2'b00, 5'd3, 1'b1, 32'hCAFEF00D, 32'h0);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b1) begin
         errors++; $display("FAIL reset_pre_flag got %b exp 1", regWriteFlag);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wrData, wAddr, regWriteFlag, load_pending, load_addr, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got wrData=%h wAddr=%0d flag=%b pend=%b laddr=%0d busy=%b exp all 0",
                  wrData, wAddr, regWriteFlag, load_pending, load_addr, busy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_no_write got flag=%b busy=%b exp 0 0", regWriteFlag, busy);
      end
   endtask

   task automatic test_back_to_back();
      drive_op(2'b00, 5'd5, 1'b1, 32'h12345678, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b1 || wrData !== 32'h12345678 || wAddr !== 5'd5) begin
         errors++; $display("FAIL b2b_first got flag=%b data=%h addr=%0d exp 1 12345678 5",
                            regWriteFlag, wrData, wAddr);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_ready_commit got %b exp 1", in_ready);
      end
      drive_op(2'b10, 5'd31, 1'b1, 32'h11111111, 32'h00400010);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b1 || wrData !== 32'h00400010 || wAddr !== 5'd31) begin
         errors++; $display("FAIL b2b_second got flag=%b data=%h addr=%0d exp 1 00400010 31",
                            regWriteFlag, wrData, wAddr);
      end
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b0 || wrData !== 32'h00400010 || wAddr !== 5'd31 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_hold got flag=%b data=%h addr=%0d busy=%b exp 0 00400010 31 0",
                            regWriteFlag, wrData, wAddr, busy);
      end
      // wbSel 11 selects the ALU result
      drive_op(2'b11, 5'd7, 1'b1, 32'hA5A5A5A5, 32'h0BADF00D);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b1 || wrData !== 32'hA5A5A5A5 || wAddr !== 5'd7) begin
         errors++; $display("FAIL wbsel11 got flag=%b data=%h addr=%0d exp 1 a5a5a5a5 7",
                            regWriteFlag, wrData, wAddr);
      end
      @(negedge clk);
   endtask

   task automatic test_signed_byte();
      drive_load(2'b00, 1'b0, 2'd2, 5'd8);
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (load_pending !== 1'b1 || load_addr !== 5'd8 || in_ready !== 1'b0 || regWriteFlag !== 1'b0) begin
            errors++; $display("FAIL sbyte_wait[%0d] got pend=%b laddr=%0d ready=%b flag=%b exp 1 8 0 0",
                               i, load_pending, load_addr, in_ready, regWriteFlag);
         end
         if (i < 2) @(negedge clk);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h00800000;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b1 || wrData !== 32'hFFFFFF80 || wAddr !== 5'd8 || load_pending !== 1'b0) begin
         errors++; $display("FAIL sbyte_commit got flag=%b data=%h addr=%0d pend=%b exp 1 ffffff80 8 0",
                            regWriteFlag, wrData, wAddr, load_pending);
      end
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b0) begin
         errors++; $display("FAIL sbyte_pulse_len got flag=%b exp 0", regWriteFlag);
      end
   endtask

   task automatic test_load(input string name, input logic [1:0] size, input logic uns,
                            input logic [1:0] off, input logic [31:0] rdata, input logic [31:0] exp);
      drive_load(size, uns, off, 5'd20);
      @(negedge clk);
      idle_inputs();
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b1 || wrData !== exp || wAddr !== 5'd20) begin
         errors++; $display("FAIL %s got flag=%b data=%h addr=%0d exp 1 %h 20",
                            name, regWriteFlag, wrData, wAddr, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reg_zero();
      drive_op(2'b00, 5'd0, 1'b1, 32'h55555555, 32'h0);
      @(negedge clk);
      drive_op(2'b00, 5'd9, 1'b0, 32'h66666666, 32'h0);
      checks++;
      if (busy !== 1'b1 || regWriteFlag !== 1'b0) begin
         errors++; $display("FAIL reg0_write got busy=%b flag=%b exp 1 0", busy, regWriteFlag);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (busy !== 1'b1 || regWriteFlag !== 1'b0 || wAddr !== 5'd9) begin
         errors++; $display("FAIL nowrite_op got busy=%b flag=%b addr=%0d exp 1 0 9",
                            busy, regWriteFlag, wAddr);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      drive_load(2'b10, 1'b0, 2'd0, 5'd12);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (load_pending !== 1'b1 || load_addr !== 5'd12) begin
         errors++; $display("FAIL flush_pre got pend=%b laddr=%0d exp 1 12", load_pending, load_addr);
      end
      flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
      drive_op(2'b00, 5'd4, 1'b1, 32'h1, 32'h0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL flush_ready got %b exp 0", in_ready);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b0 || busy !== 1'b0 || load_pending !== 1'b0) begin
         errors++; $display("FAIL flush_cancel got flag=%b busy=%b pend=%b exp 0 0 0",
                            regWriteFlag, busy, load_pending);
      end
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_after got flag=%b busy=%b exp 0 0", regWriteFlag, busy);
      end
   endtask

   task automatic test_stray();
      logic [31:0] held;
      held = wrData;
      mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (regWriteFlag !== 1'b0 || busy !== 1'b0 || wrData !== held) begin
         errors++; $display("FAIL stray_idle got flag=%b busy=%b data=%h exp 0 0 %h",
                            regWriteFlag, busy, wrData, held);
      end
      drive_load(2'b10, 1'b0, 2'd0, 5'd14);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h2468ACE0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (regWriteFlag !== 1'b0 || busy !== 1'b0 || wrData !== 32'h0 || load_pending !== 1'b0) begin
         errors++; $display("FAIL reset_in_wait got flag=%b busy=%b data=%h pend=%b exp 0 0 0 0",
                            regWriteFlag, busy, wrData, load_pending);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_signed_byte();
      test_load("uhalf_off2", 2'b01, 1'b1, 2'd2, 32'hBEEF1234, 32'h0000BEEF);
      test_load("uhalf_off3", 2'b01, 1'b1, 2'd3, 32'hBEEF1234, 32'h0000BEEF);
      test_load("word_off1",  2'b10, 1'b0, 2'd1, 32'hBEEF1234, 32'hBEEF1234);
      test_load("shalf_off2", 2'b01, 1'b0, 2'd2, 32'hBEEF1234, 32'hFFFFBEEF);
      test_load("shalf_off0", 2'b01, 1'b0, 2'd0, 32'hBEEF1234, 32'h00001234);
      test_load("ubyte_off3", 2'b00, 1'b1, 2'd3, 32'hBEEF1234, 32'h000000BE);
      test_load("sbyte_off1", 2'b00, 1'b0, 2'd1, 32'hBEEF1234, 32'h00000012);
      test_reg_zero();
      test_flush();
      test_stray();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
